debounce_bank: RTL
==================

Name: debounce_bank

Overview:
- Parametrised, multi-channel successor to the single-switch debouncer, for front-panel buttons and DIP switches on the UART board.
- Each of CHANNELS raw inputs is double-flop synchronised and debounced independently. Each channel drives:
  - a level output;
  - separate one-cycle press (rise) and release (fall) ticks.
- Sits between board pins and control logic; all outputs are in the clk domain.

Parameters:
- CHANNELS, 4, number of independent inputs (1..32).
- SYS_FREQ, 50000000, clk frequency in Hz.
- TIME_LAPES, 10, debounce interval in TIME_BASE units.
- TIME_BASE, 1000, units per second (1000 = ms).
- LONG_LAPES, 1000, long-press interval in TIME_BASE units (used only with the optional feature).
- Derived: DEB_TICKS = SYS_FREQ/TIME_BASE*TIME_LAPES; LONG_TICKS = SYS_FREQ/TIME_BASE*LONG_LAPES.
  - Counter widths are $clog2 of each value.
  - DEB_TICKS must be >= 2; the block fails elaboration otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  CHANNELS  raw asynchronous switch inputs.
- deb  output  CHANNELS  debounced level per channel.
- rise_tick  output  CHANNELS  one-cycle pulse when deb goes 0->1.
- fall_tick  output  CHANNELS  one-cycle pulse when deb goes 1->0.
- long_tick  output  CHANNELS  one-cycle long-press pulse; constant 0 without LONG_PRESS_EN.

Behaviour:
- Reset: one clock, synchronous, active-high. rst sampled high at a rising edge clears the following to 0:
  - both synchroniser stages;
  - all FSMs (to ZERO);
  - all counters;
  - deb, rise_tick, fall_tick, long_tick.
- Reset asserted mid-count aborts the count; no tick is emitted during or on exit from reset.
- Synchroniser: s1 <= sw; s2 <= s1. The FSM sees s2 only.
- Per-channel FSM, 4 states, with per-channel counter cnt:
  - ZERO (deb=0): s2=1 -> WAIT1, cnt<=0.
  - WAIT1 (deb=0):
    - s2=0 -> ZERO (glitch rejected, no tick).
    - s2=1 and cnt==DEB_TICKS-1 -> ONE, with a rise_tick pulse.
    - Otherwise cnt<=cnt+1.
  - ONE (deb=1): s2=0 -> WAIT0, cnt<=0.
  - WAIT0 (deb=1): mirror of WAIT1 with s2=1 aborting back to ONE; completion -> ZERO with a fall_tick pulse.
- deb and ticks are registered:
  - deb changes on the same edge as the state change into ONE/ZERO.
  - The tick is high for exactly that following cycle.
- Acceptance: s2 must be stable at the new level for DEB_TICKS+1 consecutive samples.
  - A pulse of <= DEB_TICKS cycles at s2 never changes deb.
  - A pulse of DEB_TICKS+1 cycles does change deb.
- Latency: deb changes at the (DEB_TICKS+3)th rising edge, counting the first edge that samples the new sw level.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous ticks in the same cycle.
- rise_tick and fall_tick are never both high on one channel in the same cycle.
- cnt never exceeds DEB_TICKS-1; no wrap-around.

Optional Feature:
- Macro: DEBOUNCE_BANK_LONG_PRESS_EN.
- Defined:
  - Per-channel long counter lcnt, cleared on entry to ONE.
  - In ONE or WAIT0, lcnt increments saturating at LONG_TICKS.
  - When lcnt reaches LONG_TICKS-1 -> LONG_TICKS, long_tick pulses once; at most one pulse per press.
  - A bounce into WAIT0 that returns to ONE does not clear lcnt.
  - Release (entry to ZERO) clears lcnt.
- Undefined: no lcnt logic is synthesised; long_tick is tied to 0.

Test Plan:
- Test parameters for all scenarios: SYS_FREQ=1000, TIME_BASE=1000, TIME_LAPES=10 (DEB_TICKS=10), CHANNELS=4, LONG_LAPES=30.
- Hold rst 5 cycles with sw=4'hF -> all outputs 0 during reset. sw then steady high -> deb=4'hF and rise_tick=4'hF at the 13th edge after rst drops, high for 1 cycle.
- Bounce sw[0] with high/low pulse widths i=1..10 cycles -> deb[0] stays 0 and no ticks. Width 11 high -> deb[0]=1 with one rise_tick[0].
- sw[1] held high to deb=1, then low 11 cycles -> single fall_tick[1], deb[1]=0. Low 10 cycles then high -> deb[1] stays 1, no fall_tick.
- sw[2] and sw[3] raised on the same edge -> rise_tick=4'b1100 in one cycle. Other channels unaffected.
- sw[0] high, rst pulsed 1 cycle at cnt=7 -> deb[0]=0, no tick. Re-acceptance takes a full 13 edges after rst drops.
- With DEBOUNCE_BANK_LONG_PRESS_EN, sw[0] held 60 cycles -> exactly one long_tick[0], 30 cycles after deb[0] rises. Without the macro -> long_tick constant 0.

Source files
------------

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: 2-flop synchroniser, per-channel debounce FSM, registered level and edge ticks.
// Optional long-press detection is compiled in when DEBOUNCE_BANK_LONG_PRESS_EN is defined.
module debounce_bank #(
  parameter int CHANNELS   = 4,
  parameter int SYS_FREQ   = 50000000,
  parameter int TIME_LAPES = 10,
  parameter int TIME_BASE  = 1000,
  parameter int LONG_LAPES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sw,
  output logic [CHANNELS-1:0] deb,
  output logic [CHANNELS-1:0] rise_tick,
  output logic [CHANNELS-1:0] fall_tick,
  output logic [CHANNELS-1:0] long_tick
);

  localparam int DEB_TICKS  = SYS_FREQ / TIME_BASE * TIME_LAPES;
  localparam int LONG_TICKS = SYS_FREQ / TIME_BASE * LONG_LAPES;
  localparam int CW         = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS - 1);

  if (DEB_TICKS < 2 || LONG_TICKS < 1 || CHANNELS < 1 || CHANNELS > 32) begin : g_bad_params
    $error("debounce_bank: DEB_TICKS must be >= 2, LONG_TICKS >= 1, CHANNELS in 1..32");
  end

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

  logic [CHANNELS-1:0] s1, s2;

  // NOTE: non-blocking keeps s2 one cycle behind s1; blocking would collapse both stages into one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        ZERO: begin
          if (s2[i]) begin
            state_d = WAIT1;
            cnt_d   = '0;
          end
        end
        WAIT1: begin
          if (!s2[i]) begin
            state_d = ZERO;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ONE;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ONE: begin
          if (!s2[i]) begin
            state_d = WAIT0;
            cnt_d   = '0;
          end
        end
        WAIT0: begin
          if (s2[i]) begin
            state_d = ONE;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ZERO;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ZERO;
      endcase
      deb_d = (state_d == ONE) || (state_d == WAIT0);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ZERO;
        cnt_q   <= '0;
        deb_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        deb_q   <= deb_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign deb[i]       = deb_q;
    assign rise_tick[i] = rise_q;
    assign fall_tick[i] = fall_q;

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_TICKS + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);
    localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_TICKS);

    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          long_q, long_d;

    // Only a real press (WAIT1->ONE) or a release clears lcnt; a bounce through WAIT0 keeps counting.
    always_comb begin
      lcnt_d = lcnt_q;
      long_d = 1'b0;
      if ((state_q == WAIT1 && state_d == ONE) || state_d == ZERO) begin
        lcnt_d = '0;
      end else if ((state_q == ONE || state_q == WAIT0) && lcnt_q != LONG_SAT) begin
        lcnt_d = lcnt_q + 1'b1;
        long_d = (lcnt_q == LONG_LAST);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lcnt_q <= '0;
        long_q <= 1'b0;
      end else begin
        lcnt_q <= lcnt_d;
        long_q <= long_d;
      end
    end

    assign long_tick[i] = long_q;
`else
    assign long_tick[i] = 1'b0;
`endif
  end

endmodule
